// File: rtl/adc_sample_sequencer.sv
// Conversion scheduler for the dual-channel SPI ADC: period/one-shot triggering, timeout
// supervision and a 2-entry FWFT output FIFO. Define ADC_SEQ_AVG_EN for 2-sample averaging.
module adc_sample_sequencer #(
   parameter int PERIOD_W = 16,
   parameter int TIMEOUT  = 1024,
   parameter int DATA_W   = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run_i,
   input  logic                  single_i,
   input  logic [PERIOD_W-1:0]   period_i,
   output logic                  adc_en_o,
   input  logic                  adc_update_i,
   input  logic [DATA_W-1:0]     adc_data0_i,
   input  logic [DATA_W-1:0]     adc_data1_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [2*DATA_W-1:0]   out_data_o,
   output logic                  busy_o,
   output logic [7:0]            overrun_cnt_o,
   output logic [7:0]            timeout_cnt_o
);

   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_CAPT = 2'd2
   } state_t;

   state_t              state, state_n;
   logic                start, to_hit, capt;
   logic [TO_W-1:0]     to_cnt;
   logic [PERIOD_W-1:0] timer, period_q;
   logic                wrap;
   logic                pend_tm, pend_sw, pend;
   logic [DATA_W-1:0]   cap0, cap1;
   logic                en_q;

   logic                push, pop, full, drop, do_push;
   logic [2*DATA_W-1:0] push_data;
   logic [2*DATA_W-1:0] mem [2];
   logic                wr_ptr, rd_ptr;
   logic [1:0]          count;
   logic [7:0]          ovr_q, tmo_q;

   // Period is sampled at each wrap, so a new period_i only applies from the next wrap on.
   assign wrap = run_i && (period_q != '0) && (timer == period_q - PERIOD_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer    <= '0;
         period_q <= '0;
      end else if (!run_i || period_q == '0 || wrap) begin
         timer    <= '0;
         period_q <= period_i;
      end else begin
         timer    <= timer + PERIOD_W'(1);
      end
   end

   // Timer and software requests are tracked apart so run_i falling drops only the former.
   assign pend = pend_tm | pend_sw;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_tm <= 1'b0;
         pend_sw <= 1'b0;
      end else begin
         if (!run_i)      pend_tm <= 1'b0;
         else if (wrap)   pend_tm <= 1'b1;
         else if (start)  pend_tm <= 1'b0;
         if (single_i)    pend_sw <= 1'b1;
         else if (start)  pend_sw <= 1'b0;
      end
   end

   always_comb begin
      state_n = state;
      start   = 1'b0;
      to_hit  = 1'b0;
      capt    = 1'b0;
      case (state)
         S_IDLE: begin
            if (pend || (run_i && period_i == '0)) begin
               start   = 1'b1;
               state_n = S_WAIT;
            end
         end
         S_WAIT: begin
            if (adc_update_i) begin
               state_n = S_CAPT;
            end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
               to_hit  = 1'b1;
               state_n = S_IDLE;
            end
         end
         S_CAPT: begin
            capt    = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         en_q   <= 1'b0;
         to_cnt <= '0;
         cap0   <= '0;
         cap1   <= '0;
         tmo_q  <= '0;
      end else begin
         state <= state_n;
         en_q  <= start;
         if (start)
            to_cnt <= '0;
         else if (state == S_WAIT)
            to_cnt <= to_cnt + TO_W'(1);
         if (state == S_WAIT && adc_update_i) begin
            cap0 <= adc_data0_i;
            cap1 <= adc_data1_i;
         end
         if (to_hit && tmo_q != 8'hFF)
            tmo_q <= tmo_q + 8'd1;
      end
   end

`ifdef ADC_SEQ_AVG_EN
   logic              phase, run_q;
   logic [DATA_W:0]   acc0, acc1, sum0, sum1;

   assign sum0      = acc0 + {1'b0, cap0};
   assign sum1      = acc1 + {1'b0, cap1};
   assign push      = capt && phase;
   assign push_data = {sum1[DATA_W:1], sum0[DATA_W:1]};

   // First capture of a pair is parked in the accumulators; the second one emits the mean.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase <= 1'b0;
         run_q <= 1'b0;
         acc0  <= '0;
         acc1  <= '0;
      end else begin
         run_q <= run_i;
         if (run_q && !run_i) begin
            phase <= 1'b0;
         end else if (capt) begin
            phase <= ~phase;
            if (!phase) begin
               acc0 <= {1'b0, cap0};
               acc1 <= {1'b0, cap1};
            end
         end
      end
   end
`else
   assign push      = capt;
   assign push_data = {cap1, cap0};
`endif

   // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
   assign pop     = out_valid_o && out_ready_i;
   assign full    = (count == 2'd2);
   assign drop    = push && full && !pop;
   assign do_push = push && !drop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
         ovr_q  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, do_push} - {1'b0, pop};
         if (drop && ovr_q != 8'hFF)
            ovr_q <= ovr_q + 8'd1;
      end
   end

   assign adc_en_o      = en_q;
   assign busy_o        = (state == S_WAIT);
   assign out_valid_o   = (count != 2'd0);
   assign out_data_o    = mem[rd_ptr];
   assign overrun_cnt_o = ovr_q;
   assign timeout_cnt_o = tmo_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Directed bench for adc_sample_sequencer with a behavioural ADC answering after a set delay.
module tb_adc_sample_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        run_i, single_i;
   logic [15:0] period_i;
   logic        adc_en_o, adc_update_i;
   logic [11:0] adc_data0_i, adc_data1_i;
   logic        out_valid_o, out_ready_i;
   logic [23:0] out_data_o;
   logic        busy_o;
   logic [7:0]  overrun_cnt_o, timeout_cnt_o;

   always #5 clk = ~clk;

   adc_sample_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .run_i         (run_i),
      .single_i      (single_i),
      .period_i      (period_i),
      .adc_en_o      (adc_en_o),
      .adc_update_i  (adc_update_i),
      .adc_data0_i   (adc_data0_i),
      .adc_data1_i   (adc_data1_i),
      .out_valid_o   (out_valid_o),
      .out_ready_i   (out_ready_i),
      .out_data_o    (out_data_o),
      .busy_o        (busy_o),
      .overrun_cnt_o (overrun_cnt_o),
      .timeout_cnt_o (timeout_cnt_o)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // ADC model state
   bit          model_on = 0;
   int          m_delay  = 10;
   logic [11:0] m_ch0 = '0, m_ch1 = '0;
   int          m_idx = 0, m_step = 0, m_answers = 0;
   bit          ready_on_capt = 0;
   time         upd_time = 0;

   // monitor state
   int          cyc = 0, en_cnt = 0, en_width_err = 0, busy_cycles = 0;
   bit          en_prev = 0, valid_prev = 0, valid_seen = 0, collect_pops = 0;
   int          en_times[$];
   int          valid_lat[$];
   logic [23:0] pop_q[$];
   logic [23:0] exp_q[$];

   always @(negedge clk) begin
      cyc++;
      if (adc_en_o) begin
         en_cnt++;
         en_times.push_back(cyc);
         if (en_prev) en_width_err++;
      end
      en_prev = adc_en_o;
      if (busy_o) busy_cycles++;
      if (out_valid_o) valid_seen = 1;
      if (out_valid_o && !valid_prev) valid_lat.push_back(int'(($time - upd_time) / 10));
      valid_prev = out_valid_o;
      if (collect_pops && out_valid_o && out_ready_i) pop_q.push_back(out_data_o);
   end

   initial begin
      adc_update_i = 1'b0;
      adc_data0_i  = '0;
      adc_data1_i  = '0;
      forever begin
         @(negedge clk);
         if (model_on && adc_en_o) begin
            repeat (m_delay) @(negedge clk);
            adc_data0_i  = m_ch0 + 12'(m_idx);
            adc_data1_i  = m_ch1 + 12'(m_idx);
            adc_update_i = 1'b1;
            upd_time     = $time;
            m_answers++;
            m_idx += m_step;
            @(negedge clk);
            adc_update_i = 1'b0;
            if (ready_on_capt) out_ready_i = 1'b1;
            @(negedge clk);
            if (ready_on_capt) begin
               out_ready_i   = 1'b0;
               ready_on_capt = 0;
            end
         end
      end
   end

   task automatic pulse_single();
      single_i = 1'b1;
      @(negedge clk);
      single_i = 1'b0;
   endtask

   task automatic clear_monitor();
      en_cnt = 0; en_width_err = 0; busy_cycles = 0; valid_seen = 0;
      en_times.delete(); valid_lat.delete(); pop_q.delete();
   endtask

   task automatic drain_and_compare(input string tag);
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
         if (out_valid_o) check_eq(tag, 32'(out_data_o), 32'(exp_q.pop_front()));
         out_ready_i = 1'b1;
         @(negedge clk);
      end
      out_ready_i = 1'b0;
      check_eq({tag, "_left"}, 32'(exp_q.size()), 32'd0);
      check_eq({tag, "_empty"}, 32'(out_valid_o), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_en"},      32'(adc_en_o),      32'd0);
      check_eq({tag, "_valid"},   32'(out_valid_o),   32'd0);
      check_eq({tag, "_data"},    32'(out_data_o),    32'd0);
      check_eq({tag, "_busy"},    32'(busy_o),        32'd0);
      check_eq({tag, "_overrun"}, 32'(overrun_cnt_o), 32'd0);
      check_eq({tag, "_timeout"}, 32'(timeout_cnt_o), 32'd0);
   endtask

   initial begin
      rst = 1'b1; run_i = 1'b0; single_i = 1'b0; period_i = '0; out_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst_hold");
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst_rel");

`ifdef ADC_SEQ_AVG_EN
      model_on = 1; m_delay = 10; m_ch0 = 12'h100; m_ch1 = 12'h200; m_idx = 0; m_step = 3;
      pulse_single();
      repeat (30) @(negedge clk);
      check_eq("avg_first_held", 32'(out_valid_o), 32'd0);
      pulse_single();
      repeat (30) @(negedge clk);
      check_eq("avg_valid", 32'(out_valid_o), 32'd1);
      check_eq("avg_data", 32'(out_data_o), 32'h201101);
`else
      // periodic sampling at period 100
      clear_monitor();
      model_on = 1; m_delay = 40; m_ch0 = 12'h123; m_ch1 = 12'hABC; m_idx = 0; m_step = 0;
      out_ready_i = 1'b1; period_i = 16'd100; collect_pops = 1;
      run_i = 1'b1;
      repeat (350) @(negedge clk);
      run_i = 1'b0;
      repeat (60) @(negedge clk);
      collect_pops = 0;
      out_ready_i  = 1'b0;
      check_eq("per_en_count", 32'(en_cnt), 32'd3);
      check_eq("per_en_width", 32'(en_width_err), 32'd0);
      if (en_times.size() >= 3) begin
         check_eq("per_interval1", 32'(en_times[1] - en_times[0]), 32'd100);
         check_eq("per_interval2", 32'(en_times[2] - en_times[1]), 32'd100);
      end
      check_eq("per_pop_count", 32'(pop_q.size()), 32'd3);
      foreach (pop_q[i]) check_eq("per_data", 32'(pop_q[i]), 32'hABC123);
      if (valid_lat.size() > 0) check_eq("per_valid_lat", 32'(valid_lat[0]), 32'd2);
      check_eq("per_valid_lat_n", 32'(valid_lat.size()), 32'd3);

      // one-shot with no ADC answer
      clear_monitor();
      model_on = 0;
      pulse_single();
      repeat (1100) @(negedge clk);
      check_eq("to_busy_cycles", 32'(busy_cycles), 32'd1024);
      check_eq("to_count", 32'(timeout_cnt_o), 32'd1);
      check_eq("to_no_valid", 32'(valid_seen), 32'd0);
      check_eq("to_en_count", 32'(en_cnt), 32'd1);
      check_eq("to_busy_end", 32'(busy_o), 32'd0);

      // back-to-back into a stalled FIFO
      clear_monitor();
      model_on = 1; m_delay = 10; m_ch0 = 12'h010; m_ch1 = 12'h800; m_idx = 0; m_step = 1;
      m_answers = 0; period_i = '0;
      run_i = 1'b1;
      for (int i = 0; i < 500 && m_answers < 5; i++) @(negedge clk);
      run_i = 1'b0;
      check_eq("b2b_answers", 32'(m_answers), 32'd5);
      repeat (20) @(negedge clk);
      check_eq("b2b_en_count", 32'(en_cnt), 32'd5);
      check_eq("b2b_overrun", 32'(overrun_cnt_o), 32'd3);
      check_eq("b2b_valid", 32'(out_valid_o), 32'd1);
      check_eq("b2b_head", 32'(out_data_o), 32'h800010);
      repeat (10) @(negedge clk);
      check_eq("b2b_head_stable", 32'(out_data_o), 32'h800010);

      // full FIFO, pop coincides with the capture cycle
      ready_on_capt = 1;
      pulse_single();
      repeat (40) @(negedge clk);
      check_eq("fullpop_overrun", 32'(overrun_cnt_o), 32'd3);
      exp_q.delete();
      exp_q.push_back(24'h801011);
      exp_q.push_back(24'h805015);
      drain_and_compare("fullpop_order");

      // reset during WAIT, stale update after release
      model_on = 1; m_delay = 30; m_step = 0;
      pulse_single();
      for (int i = 0; i < 10 && !adc_en_o; i++) @(negedge clk);
      check_eq("rw_started", 32'(adc_en_o), 32'd1);
      repeat (10) @(negedge clk);
      check_eq("rw_busy_before", 32'(busy_o), 32'd1);
      rst = 1'b1;
      #1;
      check_eq("rw_busy_async", 32'(busy_o), 32'd0);
      repeat (15) @(negedge clk);
      rst = 1'b0;
      clear_monitor();
      repeat (25) @(negedge clk);
      check_reset_outputs("rw_after");
      check_eq("rw_no_valid", 32'(valid_seen), 32'd0);
      check_eq("rw_no_start", 32'(en_cnt), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
